hot_page_addr_writer: RTL and testbench

//  Producer end of the hot-page address ring in host memory: accepts 4KB-aligned hot page addresses, packs
//  16 x 32-bit page numbers (addr[43:12]) per 512-bit line, and writes each line to a host ring via single-beat
//  AXI4 AW/W/B. The host consumer reads lines and returns a consumed-line count via CSR.

---
 rtl/hot_page_addr_writer.sv | 172 +++++++++++++++++
 tb/tb_hot_page_addr_writer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hot_page_addr_writer.sv
`default_nettype none
// =============================================================================
// Module   : hot_page_addr_writer
// Desc     : Packs 16 hot page numbers per 64B line and writes each line to a
//            host ring with single-beat AXI4 writes. HOT_PAGE_WR_DEDUP_EN
//            drops page numbers already present in the line being packed.
// Revision : 1.0 - initial release
// =============================================================================
module hot_page_addr_writer #(
    parameter int          RING_LINES    = 64,
    parameter int          FLUSH_TIMEOUT = 1024,
    parameter logic [11:0] AWID_VAL      = 12'h0
) (
    input  logic         axi4_mm_clk,
    input  logic         axi4_mm_rst,
    input  logic [63:0]  hot_addr,
    input  logic         hot_addr_valid,
    output logic         hot_addr_ready,
    input  logic [63:0]  ring_base_pAddr,
    input  logic         ring_enable,
    input  logic [63:0]  cons_idx,
    input  logic [5:0]   csr_awuser,
    output logic [11:0]  awid,
    output logic [63:0]  awaddr,
    output logic [5:0]   awuser,
    output logic         awvalid,
    input  logic         awready,
    output logic [511:0] wdata,
    output logic [63:0]  wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [11:0]  bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready,
    output logic [63:0]  prod_idx,
    output logic         wr_err,
    output logic [31:0]  dedup_cnt
);
    localparam int IDX_W = $clog2(RING_LINES);
    localparam int TMR_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(FLUSH_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT_B = 2'd2
    } state_t;

    state_t             state;
    logic [511:0]       pack;
    logic [4:0]         fill;
    logic [TMR_W-1:0]   timer;
    logic [63:0]        issue_idx;
    logic               run;
    logic               active;
    logic               ring_full;
    logic               line_ready;
    logic               capture;
    logic               accept;
    logic               dup_hit;
    logic [31:0]        page;
    logic               unused_inputs;

    assign page          = hot_addr[43:12];
    assign unused_inputs = ^{bid, hot_addr[63:44], hot_addr[11:0]};

    assign active     = ring_enable & (ring_base_pAddr != 64'd0);
    assign ring_full  = (issue_idx - cons_idx) >= 64'(RING_LINES);
    assign line_ready = (fill == 5'd16) ||
                        ((FLUSH_TIMEOUT != 0) && (fill != 5'd0) && (timer == TMR_MAX));
    assign capture    = (state == ST_IDLE) & line_ready & ~ring_full & active;

    // Ready is held low in the capture cycle so an entry never races the buffer clear.
    assign hot_addr_ready = run & active & (fill < 5'd16) & ~capture;
    assign accept         = hot_addr_valid & hot_addr_ready;

    assign awid   = AWID_VAL;
    assign wstrb  = '1;
    assign wlast  = 1'b1;
    assign bready = 1'b1;

`ifdef HOT_PAGE_WR_DEDUP_EN
    logic [15:0] slot_match;
    logic [31:0] dedup_q;

    for (genvar i = 0; i < 16; i++) begin : g_dedup
        assign slot_match[i] = (pack[i*32 +: 32] == page) && (5'(i) < fill);
    end
    assign dup_hit   = |slot_match;
    assign dedup_cnt = dedup_q;

    always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
        if (axi4_mm_rst) begin
            dedup_q <= '0;
        end else if (accept && dup_hit && (dedup_q != 32'hFFFF_FFFF)) begin
            dedup_q <= dedup_q + 32'd1;
        end
    end
`else
    assign dup_hit   = 1'b0;
    assign dedup_cnt = 32'd0;
`endif

    always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
        if (axi4_mm_rst) begin
            pack  <= '0;
            fill  <= '0;
            timer <= '0;
        end else if (capture) begin
            pack  <= '0;
            fill  <= '0;
            timer <= '0;
        end else if (accept) begin
            timer <= '0;
            if (!dup_hit) begin
                pack[{fill[3:0], 5'd0} +: 32] <= page;
                fill                          <= fill + 5'd1;
            end
        end else if ((fill != 5'd0) && (timer != TMR_MAX)) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
        if (axi4_mm_rst) begin
            state     <= ST_IDLE;
            run       <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            awaddr    <= '0;
            awuser    <= '0;
            wdata     <= '0;
            issue_idx <= '0;
            prod_idx  <= '0;
            wr_err    <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (capture) begin
                        wdata     <= pack;
                        awaddr    <= ring_base_pAddr + 64'({issue_idx[IDX_W-1:0], 6'd0});
                        awuser    <= csr_awuser;
                        awvalid   <= 1'b1;
                        wvalid    <= 1'b1;
                        issue_idx <= issue_idx + 64'd1;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if ((~awvalid | awready) & (~wvalid | wready)) begin
                        state <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    // Error responses still advance the producer index to keep ring order.
                    if (bvalid) begin
                        prod_idx <= prod_idx + 64'd1;
                        wr_err   <= wr_err | (bresp != 2'b00);
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hot_page_addr_writer.sv
`default_nettype none
// Testbench for hot_page_addr_writer: directed stimulus, expected ring writes
// queued by the stimulus and compared by an independent write monitor.
module tb_hot_page_addr_writer;
    localparam int          RL   = 4;
    localparam int          FT   = 8;
    localparam logic [11:0] AWID = 12'hA5;
    localparam logic [63:0] BASE = 64'h1000_0000;
    localparam logic [5:0]  USER = 6'h2A;

    logic         clk;
    logic         rst;
    logic [63:0]  hot_addr;
    logic         hot_addr_valid;
    logic         hot_addr_ready;
    logic [63:0]  ring_base;
    logic         ring_enable;
    logic [63:0]  cons_idx;
    logic [11:0]  awid;
    logic [63:0]  awaddr;
    logic [5:0]   awuser;
    logic         awvalid;
    logic         awready;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [11:0]  bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [63:0]  prod_idx;
    logic         wr_err;
    logic [31:0]  dedup_cnt;

    typedef struct {
        logic [63:0]  addr;
        logic [511:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  aw_hs_total = 0;
    int  w_hs_total  = 0;
    int  b_total     = 0;
    int  writes_seen = 0;
    int  aw_delay    = 0;
    int  w_delay     = 0;
    logic [1:0] bresp_cfg = 2'b00;
    logic       b_hold    = 1'b0;

    hot_page_addr_writer #(
        .RING_LINES    (RL),
        .FLUSH_TIMEOUT (FT),
        .AWID_VAL      (AWID)
    ) dut (
        .axi4_mm_clk     (clk),
        .axi4_mm_rst     (rst),
        .hot_addr        (hot_addr),
        .hot_addr_valid  (hot_addr_valid),
        .hot_addr_ready  (hot_addr_ready),
        .ring_base_pAddr (ring_base),
        .ring_enable     (ring_enable),
        .cons_idx        (cons_idx),
        .csr_awuser      (USER),
        .awid            (awid),
        .awaddr          (awaddr),
        .awuser          (awuser),
        .awvalid         (awvalid),
        .awready         (awready),
        .wdata           (wdata),
        .wstrb           (wstrb),
        .wlast           (wlast),
        .wvalid          (wvalid),
        .wready          (wready),
        .bid             (bid),
        .bresp           (bresp),
        .bvalid          (bvalid),
        .bready          (bready),
        .prod_idx        (prod_idx),
        .wr_err          (wr_err),
        .dedup_cnt       (dedup_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_line(input logic [63:0] addr, input logic [31:0] first_page, input int n);
        wr_t w;
        w.addr = addr;
        w.data = '0;
        for (int i = 0; i < n; i++) w.data[i*32 +: 32] = first_page + 32'(i);
        exp_q.push_back(w);
    endtask

    // Junk in the ignored address bits checks that only [43:12] is packed.
    task automatic send_page(input logic [31:0] page);
        int c;
        hot_addr       = 64'hABC0_0000_0000_0000 | (64'(page) << 12) | 64'h5A5;
        hot_addr_valid = 1'b1;
        c = 0;
        @(negedge clk);
        while (!hot_addr_ready && c < 300) begin
            c++;
            @(negedge clk);
        end
        if (!hot_addr_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: page %h never accepted", page);
        end
        @(posedge clk); #1;
        hot_addr_valid = 1'b0;
    endtask

    task automatic wait_prod(input logic [63:0] n, input string name);
        int c;
        c = 0;
        @(negedge clk);
        while (prod_idx !== n && c < 400) begin
            c++;
            @(negedge clk);
        end
        check(name, prod_idx, n);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awvalid"}, 64'(awvalid), 64'd0);
        check({tag, "_wvalid"},  64'(wvalid),  64'd0);
        check({tag, "_awaddr"},  awaddr,       64'd0);
        check({tag, "_prod"},    prod_idx,     64'd0);
        check({tag, "_wr_err"},  64'(wr_err),  64'd0);
        check({tag, "_ready"},   64'(hot_addr_ready), 64'd0);
        check({tag, "_bready"},  64'(bready),  64'd1);
        check({tag, "_dedup"},   64'(dedup_cnt), 64'd0);
    endtask

    // AXI slave with programmable handshake delays; B follows AW and W.
    initial begin : axi_slave
        int aw_cnt;
        int w_cnt;
        aw_cnt = 0;
        w_cnt  = 0;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        bid     = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                awready = 1'b0;
                wready  = 1'b0;
                bvalid  = 1'b0;
                aw_cnt  = 0;
                w_cnt   = 0;
                b_total = aw_hs_total;
            end else begin
                if (!awvalid) begin
                    awready = 1'b0;
                    aw_cnt  = 0;
                end else if (aw_cnt >= aw_delay) begin
                    awready = 1'b1;
                end else begin
                    awready = 1'b0;
                    aw_cnt++;
                end
                if (!wvalid) begin
                    wready = 1'b0;
                    w_cnt  = 0;
                end else if (w_cnt >= w_delay) begin
                    wready = 1'b1;
                end else begin
                    wready = 1'b0;
                    w_cnt++;
                end
                if (bvalid) begin
                    bvalid = 1'b0;
                    b_total++;
                end else if (!b_hold && aw_hs_total > b_total && w_hs_total > b_total) begin
                    bvalid = 1'b1;
                    bresp  = bresp_cfg;
                    bid    = AWID;
                end
            end
        end
    end

    // Write monitor: pairs AW and W handshakes and compares with the queue head.
    initial begin : monitor
        logic [63:0]  got_addr;
        logic [511:0] got_data;
        logic         have_aw;
        logic         have_w;
        wr_t          e;
        have_aw = 1'b0;
        have_w  = 1'b0;
        got_addr = '0;
        got_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_aw = 1'b0;
                have_w  = 1'b0;
            end else begin
                if (awvalid && awready) begin
                    got_addr = awaddr;
                    have_aw  = 1'b1;
                    aw_hs_total++;
                    check("awid", 64'(awid), 64'(AWID));
                    check("awuser", 64'(awuser), 64'(USER));
                end
                if (wvalid && wready) begin
                    got_data = wdata;
                    have_w   = 1'b1;
                    w_hs_total++;
                    check("wstrb", wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
                    check("wlast", 64'(wlast), 64'd1);
                end
                if (have_aw && have_w) begin
                    have_aw = 1'b0;
                    have_w  = 1'b0;
                    writes_seen++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_write: awaddr %h with empty expectation queue", got_addr);
                    end else begin
                        e = exp_q.pop_front();
                        if (got_addr !== e.addr || got_data !== e.data) begin
                            n_fail++;
                            $display("FAIL write_%0d: awaddr %h data %h required awaddr %h data %h",
                                     writes_seen, got_addr, got_data, e.addr, e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int ws;
        int n;
        wr_t w;
        rst            = 1'b1;
        hot_addr       = '0;
        hot_addr_valid = 1'b0;
        ring_base      = BASE;
        ring_enable    = 1'b1;
        cons_idx       = 64'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: one full line at ring slot 0
        push_line(BASE, 32'h10, 16);
        for (int i = 0; i < 16; i++) send_page(32'h10 + 32'(i));
        wait_prod(64'd1, "t1_prod");
        check("t1_wr_err", 64'(wr_err), 64'd0);

        // 2: ring of 4 fills up, fifth line waits for the consumer
        cons_idx = 64'd1;
        push_line(BASE + 64'h40, 32'h20_0000, 16);
        push_line(BASE + 64'h80, 32'h20_0010, 16);
        push_line(BASE + 64'hC0, 32'h20_0020, 16);
        push_line(BASE + 64'h00, 32'h20_0030, 16);
        push_line(BASE + 64'h40, 32'h20_0040, 16);
        for (int i = 0; i < 80; i++) send_page(32'h20_0000 + 32'(i));
        wait_prod(64'd5, "t2_prod_full");
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t2_ready_full", 64'(hot_addr_ready), 64'd0);
        check("t2_awvalid_full", 64'(awvalid), 64'd0);
        @(posedge clk); #1;
        cons_idx = 64'd2;
        wait_prod(64'd6, "t2_prod_release");

        // 3: partial line flushed by idle timeout
        cons_idx = 64'd6;
        push_line(BASE + 64'h80, 32'h300, 3);
        for (int i = 0; i < 3; i++) send_page(32'h300 + 32'(i));
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!awvalid && n < 50);
        check("t3_flush_latency", 64'(n), 64'd9);
        wait_prod(64'd7, "t3_prod");

        // 4: delayed AW with error response, then delayed W
        aw_delay  = 5;
        w_delay   = 0;
        bresp_cfg = 2'b10;
        push_line(BASE + 64'hC0, 32'h400, 16);
        for (int i = 0; i < 16; i++) send_page(32'h400 + 32'(i));
        wait_prod(64'd8, "t4a_prod");
        check("t4a_wr_err", 64'(wr_err), 64'd1);
        aw_delay  = 0;
        w_delay   = 5;
        bresp_cfg = 2'b00;
        push_line(BASE + 64'h00, 32'h500, 16);
        for (int i = 0; i < 16; i++) send_page(32'h500 + 32'(i));
        wait_prod(64'd9, "t4b_prod");
        check("t4b_wr_err_sticky", 64'(wr_err), 64'd1);
        w_delay = 0;

        // 5: duplicate page within a line
        w.addr = BASE + 64'h40;
        w.data = '0;
`ifdef HOT_PAGE_WR_DEDUP_EN
        w.data[31:0]  = 32'h5;
        w.data[63:32] = 32'h6;
`else
        w.data[31:0]  = 32'h5;
        w.data[63:32] = 32'h5;
        w.data[95:64] = 32'h6;
`endif
        exp_q.push_back(w);
        send_page(32'h5);
        send_page(32'h5);
        send_page(32'h6);
        wait_prod(64'd10, "t5_prod");
`ifdef HOT_PAGE_WR_DEDUP_EN
        check("t5_dedup_cnt", 64'(dedup_cnt), 64'd1);
`else
        check("t5_dedup_cnt", 64'(dedup_cnt), 64'd0);
`endif

        // 6: reset while waiting for B, then restart from slot 0
        cons_idx = 64'd10;
        b_hold   = 1'b1;
        ws       = writes_seen;
        push_line(BASE + 64'h80, 32'h600, 16);
        for (int i = 0; i < 16; i++) send_page(32'h600 + 32'(i));
        n = 0;
        while (writes_seen < ws + 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6_write_issued", 64'(writes_seen), 64'(ws + 1));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_reset");
        @(posedge clk); #1;
        rst      = 1'b0;
        b_hold   = 1'b0;
        cons_idx = 64'd0;
        push_line(BASE, 32'h700, 16);
        for (int i = 0; i < 16; i++) send_page(32'h700 + 32'(i));
        wait_prod(64'd1, "t6_prod_after_reset");
        check("t6_wr_err", 64'(wr_err), 64'd0);

        repeat (5) @(posedge clk);
        check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        check("total_writes", 64'(writes_seen), 64'd12);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
